// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - two-master request/ack bus plus data-memory port of dm_arbiter
interface dm_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din;
  logic          dm_we;
  logic [DW-1:0] dm_dout;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output dm_addr, dm_din, dm_we,
    input  dm_dout
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  dm_addr, dm_din, dm_we,
    output dm_dout
  );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-master data-memory arbiter; define DM_ARB_RR_EN for round-robin
module dm_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          owner;
  logic          grant;
  logic          any_req;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] m0_rdata_q;
  logic [DW-1:0] m1_rdata_q;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef DM_ARB_RR_EN
  logic last_owner;

  // On contention the master that did not win last time is favoured.
  always_comb begin
    grant = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      grant = ~last_owner;
    end else begin
      grant = ~bus.m0_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_owner <= grant;
    end
  end
`else
  always_comb begin
    grant = ~bus.m0_req;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACC;
      ACC:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      owner     <= grant;
      cmd_we    <= grant ? bus.m1_we    : bus.m0_we;
      cmd_addr  <= grant ? bus.m1_addr  : bus.m0_addr;
      cmd_wdata <= grant ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else if (state == ACC && !cmd_we) begin
      if (owner) begin
        m1_rdata_q <= bus.dm_dout;
      end else begin
        m0_rdata_q <= bus.dm_dout;
      end
    end
  end

  // Write enable is state-decoded so an async reset in ACC kills it at once.
  assign bus.dm_addr  = cmd_addr;
  assign bus.dm_din   = cmd_wdata;
  assign bus.dm_we    = (state == ACC) && cmd_we;
  assign bus.m0_ack   = (state == DONE) && !owner;
  assign bus.m1_ack   = (state == DONE) && owner;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter with a behavioural data memory
module tb_dm_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk;
  logic rst;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_din;
  end
  assign bus.dm_dout = mem[bus.dm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic preset(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic run_access(input int m, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output int lat,
                            output logic [DW-1:0] rd, output int other_acks,
                            output int we_cycles);
    lat = -1; rd = '0; other_acks = 0; we_cycles = 0;
    @(negedge clk);
    if (m == 0) begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (bus.dm_we) we_cycles++;
      if (m == 0) begin
        if (bus.m1_ack) other_acks++;
        if (bus.m0_ack) begin lat = c; rd = bus.m0_rdata; end
      end else begin
        if (bus.m0_ack) other_acks++;
        if (bus.m1_ack) begin lat = c; rd = bus.m1_rdata; end
      end
    end
    @(negedge clk);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.m0_ack !== 1'b0) begin n_fail++; $display("FAIL reset_m0_ack: got %b expected 0", bus.m0_ack); end
    n_checks++; if (bus.m1_ack !== 1'b0) begin n_fail++; $display("FAIL reset_m1_ack: got %b expected 0", bus.m1_ack); end
    n_checks++; if (bus.m0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_m0_rdata: got %h expected 0", bus.m0_rdata); end
    n_checks++; if (bus.m1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_m1_rdata: got %h expected 0", bus.m1_rdata); end
    n_checks++; if (bus.dm_we !== 1'b0) begin n_fail++; $display("FAIL reset_dm_we: got %b expected 0", bus.dm_we); end
    n_checks++; if (bus.dm_addr !== 10'h0) begin n_fail++; $display("FAIL reset_dm_addr: got %h expected 0", bus.dm_addr); end
    n_checks++; if (bus.dm_din !== 32'h0) begin n_fail++; $display("FAIL reset_dm_din: got %h expected 0", bus.dm_din); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_m0_write_read;
    int lat, oth, wec;
    logic [DW-1:0] rd;
    run_access(0, 1'b1, 10'h005, 32'hDEADBEEF, lat, rd, oth, wec);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL m0_write_latency: got %0d expected 2", lat); end
    n_checks++; if (wec !== 1) begin n_fail++; $display("FAIL m0_write_we_cycles: got %0d expected 1", wec); end
    n_checks++; if (bus.m0_rdata !== 32'h0) begin n_fail++; $display("FAIL m0_write_keeps_rdata: got %h expected 0", bus.m0_rdata); end
    n_checks++; if (oth !== 0) begin n_fail++; $display("FAIL m0_write_m1_ack: got %0d expected 0", oth); end
    run_access(0, 1'b0, 10'h005, 32'h0, lat, rd, oth, wec);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL m0_read_latency: got %0d expected 2", lat); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL m0_read_data: got %h expected deadbeef", rd); end
    n_checks++; if (oth !== 0) begin n_fail++; $display("FAIL m0_read_m1_ack: got %0d expected 0", oth); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL m0_rdata_held: got %h expected deadbeef", bus.m0_rdata); end
  endtask

  task automatic test_m1_read;
    int lat, oth, wec;
    logic [DW-1:0] rd;
    preset(10'h3FF, 32'h12345678);
    run_access(1, 1'b0, 10'h3FF, 32'h0, lat, rd, oth, wec);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL m1_read_latency: got %0d expected 2", lat); end
    n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL m1_read_data: got %h expected 12345678", rd); end
    n_checks++; if (wec !== 0) begin n_fail++; $display("FAIL m1_read_dm_we: got %0d expected 0", wec); end
    n_checks++; if (oth !== 0) begin n_fail++; $display("FAIL m1_read_m0_ack: got %0d expected 0", oth); end
  endtask

  task automatic test_contention;
    int m0_acks, m1_acks, both, n_ack, lat, oth, wec;
    int ord [3];
    int exp_ord [3];
    int exp_m0, exp_m1;
    logic a0, a1;
    logic [DW-1:0] rd, exp_m1_word;
    m0_acks = 0; m1_acks = 0; both = 0; n_ack = 0;
    ord[0] = -1; ord[1] = -1; ord[2] = -1;
`ifdef DM_ARB_RR_EN
    exp_m0 = 2; exp_m1 = 1; exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0;
    exp_m1_word = 32'hB1B1B1B1;
`else
    exp_m0 = 3; exp_m1 = 0; exp_ord[0] = 0; exp_ord[1] = 0; exp_ord[2] = 0;
    exp_m1_word = 32'h0;
`endif
    preset(10'h020, 32'h0);
    preset(10'h021, 32'h0);
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 10'h020; bus.m0_wdata = 32'hA0A0A0A0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 10'h021; bus.m1_wdata = 32'hB1B1B1B1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      a0 = bus.m0_ack; a1 = bus.m1_ack;
      if (a0 && a1) both++;
      if (a0) begin m0_acks++; if (n_ack < 3) ord[n_ack] = 0; n_ack++; end
      if (a1) begin m1_acks++; if (n_ack < 3) ord[n_ack] = 1; n_ack++; end
      @(negedge clk);
      bus.m0_req = !a0;
      bus.m1_req = !a1;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    n_checks++; if (m0_acks !== exp_m0) begin n_fail++; $display("FAIL contention_m0_acks: got %0d expected %0d", m0_acks, exp_m0); end
    n_checks++; if (m1_acks !== exp_m1) begin n_fail++; $display("FAIL contention_m1_acks: got %0d expected %0d", m1_acks, exp_m1); end
    n_checks++; if (both !== 0) begin n_fail++; $display("FAIL contention_dual_ack: got %0d expected 0", both); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ord[i] !== exp_ord[i]) begin n_fail++; $display("FAIL contention_order[%0d]: got %0d expected %0d", i, ord[i], exp_ord[i]); end
    end
    run_access(0, 1'b0, 10'h020, 32'h0, lat, rd, oth, wec);
    n_checks++; if (rd !== 32'hA0A0A0A0) begin n_fail++; $display("FAIL contention_m0_word: got %h expected a0a0a0a0", rd); end
    run_access(0, 1'b0, 10'h021, 32'h0, lat, rd, oth, wec);
    n_checks++; if (rd !== exp_m1_word) begin n_fail++; $display("FAIL contention_m1_word: got %h expected %h", rd, exp_m1_word); end
  endtask

  task automatic test_req_held;
    int acks, consec, first_ack, last_ack, bad_gap;
    logic prev;
    acks = 0; consec = 0; first_ack = -1; last_ack = -1; bad_gap = 0; prev = 1'b0;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'h005; bus.m0_wdata = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (bus.m0_ack) begin
        if (prev) consec++;
        if (last_ack >= 0 && c - last_ack != 3) bad_gap++;
        if (first_ack < 0) first_ack = c;
        last_ack = c;
        acks++;
      end
      prev = bus.m0_ack;
    end
    @(negedge clk);
    bus.m0_req = 1'b0;
    n_checks++; if (acks !== 3) begin n_fail++; $display("FAIL held_ack_count: got %0d expected 3", acks); end
    n_checks++; if (first_ack !== 2) begin n_fail++; $display("FAIL held_first_ack: got %0d expected 2", first_ack); end
    n_checks++; if (bad_gap !== 0) begin n_fail++; $display("FAIL held_ack_spacing: got %0d bad gaps expected 0", bad_gap); end
    n_checks++; if (consec !== 0) begin n_fail++; $display("FAIL held_consecutive_ack: got %0d expected 0", consec); end
    n_checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL held_rdata: got %h expected deadbeef", bus.m0_rdata); end
  endtask

  task automatic test_reset_mid_access;
    int acks, lat, oth, wec;
    logic [DW-1:0] rd;
    preset(10'h010, 32'h0);
    @(negedge clk);
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 10'h010; bus.m1_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    n_checks++; if (bus.dm_we !== 1'b1) begin n_fail++; $display("FAIL midrst_acc_we: got %b expected 1", bus.dm_we); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.dm_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we_drop: got %b expected 0", bus.dm_we); end
    n_checks++; if (bus.dm_addr !== 10'h0) begin n_fail++; $display("FAIL midrst_dm_addr: got %h expected 0", bus.dm_addr); end
    n_checks++; if (bus.dm_din !== 32'h0) begin n_fail++; $display("FAIL midrst_dm_din: got %h expected 0", bus.dm_din); end
    n_checks++; if (bus.m0_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_m0_rdata: got %h expected 0", bus.m0_rdata); end
    n_checks++; if (bus.m1_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_m1_rdata: got %h expected 0", bus.m1_rdata); end
    acks = 0;
    @(negedge clk);
    bus.m1_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.m0_ack || bus.m1_ack) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL midrst_no_ack: got %0d expected 0", acks); end
    n_checks++; if (mem[10'h010] !== 32'h0) begin n_fail++; $display("FAIL midrst_mem_word: got %h expected 0", mem[10'h010]); end
    run_access(0, 1'b0, 10'h010, 32'h0, lat, rd, oth, wec);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_readback: got %h expected 0", rd); end
  endtask

  initial begin
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    rst = 1'b1;
    test_reset();
    test_m0_write_read();
    test_m1_read();
    test_contention();
    test_req_held();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
